// File: rtl/timer_pkg.sv
// timer_pkg: shared register offsets, CTRL bit positions and bus FSM states for the timer
package timer_pkg;
  localparam logic [4:0] ADDR_CTRL = 5'h00;
  localparam logic [4:0] ADDR_PSC  = 5'h04;
  localparam logic [4:0] ADDR_ARR  = 5'h08;
  localparam logic [4:0] ADDR_CNT  = 5'h0C;
  localparam logic [4:0] ADDR_STAT = 5'h10;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int CTRL_IRQEN = 2;
  typedef enum logic {IDLE, ACK} bus_state_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the enabled clock by psc+1, pulsing tick on the last count
module timer_prescaler (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        en,
  input  logic [15:0] psc,
  input  logic        clr,
  output logic        tick
);
  logic [15:0] pcnt;
  assign tick = en && (pcnt == psc);
  // count 0..psc while enabled; a register write restarts the period
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) pcnt <= '0;
    else if (clr) pcnt <= '0;
    else if (en) pcnt <= tick ? '0 : pcnt + 16'd1;
endmodule

// File: rtl/timer_periph.sv
// timer_periph: APB-attached 32-bit match timer with prescaler and level interrupt
module timer_periph import timer_pkg::*; (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);
  bus_state_t state;
  logic [2:0]  ctrl;
  logic [15:0] psc;
  logic [31:0] arr, cnt, rdata;
  logic [4:0]  addr;
  logic        match, tick, access, wr, hit, unused;
  assign unused = ^{PADDR[31:5], PADDR[1:0]};
  assign addr   = {PADDR[4:2], 2'b00};
  assign access = (state == IDLE) && PSEL && PENABLE;
  assign wr     = access && PWRITE;
  assign hit    = tick && (cnt == arr);
  assign irq    = match && ctrl[CTRL_IRQEN];
  timer_prescaler u_psc (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .en     (ctrl[CTRL_EN]),
    .psc    (psc),
    .clr    (wr && (addr == ADDR_CNT || addr == ADDR_PSC)),
    .tick   (tick)
  );
  // read mux sees pre-update register values of the capturing edge
  always_comb
    rdata = addr == ADDR_CTRL ? {29'd0, ctrl} :
            addr == ADDR_PSC  ? {16'd0, psc} :
            addr == ADDR_ARR  ? arr :
            addr == ADDR_CNT  ? cnt :
            addr == ADDR_STAT ? {31'd0, match} : '0;
  // two-state bus handshake: one wait state, read data captured on entry to ACK
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      state  <= IDLE;
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      state  <= access ? ACK : IDLE;
      PREADY <= access;
      if (access) PRDATA <= rdata;
    end
  // configuration registers; a CTRL write beats the one-shot EN clear
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      ctrl <= '0;
      psc  <= '0;
      arr  <= '1;
    end else begin
      if (wr && addr == ADDR_CTRL) ctrl <= PWDATA[2:0];
      else if (hit && !ctrl[CTRL_AR]) ctrl[CTRL_EN] <= 1'b0;
      if (wr && addr == ADDR_PSC) psc <= PWDATA[15:0];
      if (wr && addr == ADDR_ARR) arr <= PWDATA;
    end
  // counter and match flag; CNT writes beat increments, match set beats W1C
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      cnt   <= '0;
      match <= 1'b0;
    end else begin
      if (wr && addr == ADDR_CNT) cnt <= PWDATA;
      else if (tick) cnt <= hit ? '0 : cnt + 32'd1;
      if (hit) match <= 1'b1;
      else if (wr && addr == ADDR_STAT && PWDATA[0]) match <= 1'b0;
    end
endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph: directed APB register and timer behaviour checks for timer_periph
module tb_timer_periph;
  logic        PCLK = 1'b0, PRESET = 1'b0, PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, irq;
  int          checks = 0, errors = 0;
  logic [31:0] rd;
  logic        irq_c;
  int          n;
  timer_periph dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .irq     (irq)
  );
  always #5 PCLK = ~PCLK;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = w; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("pready_setup", {31'd0, PREADY}, 32'd0);
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("pready_ack", {31'd0, PREADY}, 32'd1);
    irq_c = irq;
    r = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("pready_idle", {31'd0, PREADY}, 32'd0);
  endtask
  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    acc(1'b1, a, d, r);
  endtask
  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    acc(1'b0, a, 32'd0, rd);
    chk(tag, rd, exp);
  endtask
  task automatic cyc(input int k);
    repeat (k) @(posedge PCLK);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    rdchk("rst_ctrl", 32'h00, 32'h0);
    rdchk("rst_psc", 32'h04, 32'h0);
    rdchk("rst_arr", 32'h08, 32'hFFFF_FFFF);
    rdchk("rst_cnt", 32'h0C, 32'h0);
    rdchk("rst_stat", 32'h10, 32'h0);
    rdchk("rd_unmapped14", 32'h14, 32'h0);
    wr32(32'h04, 32'hABCD_0003);
    rdchk("psc_mask", 32'h04, 32'h3);
    wr32(32'h00, 32'hFFFF_FFF8);
    rdchk("ctrl_mask", 32'h00, 32'h0);
    wr32(32'h08, 32'd4);
    wr32(32'h00, 32'h7);
    n = 1;
    while (!irq && n < 100) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("match_latency", n, 20);
    rdchk("ar_cnt_wrap", 32'h0C, 32'h0);
    rdchk("ar_en_kept", 32'h00, 32'h7);
    chk("ar_irq", {31'd0, irq}, 32'd1);
    rdchk("ar_match", 32'h10, 32'h1);
    wr32(32'h00, 32'h0);
    wr32(32'h10, 32'h1);
    wr32(32'h0C, 32'h0);
    wr32(32'h04, 32'h0);
    wr32(32'h08, 32'd2);
    wr32(32'h00, 32'h1);
    cyc(3);
    rdchk("os_en_clear", 32'h00, 32'h0);
    rdchk("os_match", 32'h10, 32'h1);
    rdchk("os_cnt", 32'h0C, 32'h0);
    chk("os_irq_masked", {31'd0, irq}, 32'd0);
    wr32(32'h10, 32'h1);
    rdchk("os_w1c", 32'h10, 32'h0);
    wr32(32'h08, 32'h0);
    wr32(32'h00, 32'h7);
    chk("psc0_irq", {31'd0, irq}, 32'd1);
    wr32(32'h10, 32'h1);
    chk("set_beats_w1c", {31'd0, irq_c}, 32'd1);
    wr32(32'h00, 32'h4);
    chk("held_irq", {31'd0, irq}, 32'd1);
    rdchk("psc0_cnt", 32'h0C, 32'h0);
    wr32(32'h10, 32'h1);
    chk("w1c_irq_fall", {31'd0, irq_c}, 32'd0);
    rdchk("w1c_stat", 32'h10, 32'h0);
    wr32(32'h08, 32'd1000);
    wr32(32'h04, 32'd7);
    wr32(32'h00, 32'h1);
    wr32(32'h0C, 32'h10);
    rdchk("cntwr_imm", 32'h0C, 32'h10);
    wr32(32'h0C, 32'h10);
    cyc(4);
    rdchk("cntwr_edge8_pre", 32'h0C, 32'h10);
    wr32(32'h0C, 32'h10);
    cyc(5);
    rdchk("cntwr_after8", 32'h0C, 32'h11);
    wr32(32'h00, 32'h0);
    wr32(32'h0C, 32'h55);
    wr32(32'h18, 32'hFFFF_FFFF);
    rdchk("ign_ctrl", 32'h00, 32'h0);
    rdchk("ign_psc", 32'h04, 32'h7);
    rdchk("ign_arr", 32'h08, 32'd1000);
    rdchk("ign_cnt", 32'h0C, 32'h55);
    rdchk("ign_stat", 32'h10, 32'h0);
    rdchk("ign_rd18", 32'h18, 32'h0);
    wr32(32'h00, 32'h4);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h7; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_in_ack", {31'd0, PREADY}, 32'd1);
    PRESET = 1'b0;
    #1;
    chk("abort_pready", {31'd0, PREADY}, 32'd0);
    chk("abort_prdata", PRDATA, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    rdchk("abort_ctrl", 32'h00, 32'h0);
    rdchk("abort_arr", 32'h08, 32'hFFFF_FFFF);
    rdchk("abort_psc", 32'h04, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_periph.md
TIMER_PERIPH -- requirements
Module: timer_periph

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose `PCLK  in  1  APB clock`; all state changes on its rising edge.
REQ-003 SHALL expose `PRESET  in  1  asynchronous active-low reset`.
REQ-004 SHALL expose `PADDR  in  32  byte address`; only PADDR[4:2] decoded.
REQ-005 SHALL expose `PWRITE  in  1  1 = write, 0 = read`.
REQ-006 SHALL expose `PENABLE  in  1  APB access phase`.
REQ-007 SHALL expose `PWDATA  in  32  write data`.
REQ-008 SHALL expose `PSEL  in  1  slave select from the bus decoder`.
REQ-009 SHALL expose `PRDATA  out  32  read data, registered`.
REQ-010 SHALL expose `PREADY  out  1  transfer complete, registered`.
REQ-011 SHALL expose `irq  out  1  timer match interrupt, level`.

Function
REQ-012 Register map SHALL be:
- 0x00 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
- 0x04 PSC: bits[15:0], prescaler.
- 0x08 ARR: bits[31:0], match value.
- 0x0C CNT: bits[31:0], counter.
- 0x10 STAT: bit0 MATCH, write-1-to-clear.
- Other offsets read 0; writes to them are ignored.
REQ-013 Bus FSM SHALL have two states, IDLE and ACK:
- IDLE->ACK when PSEL&PENABLE.
- ACK->IDLE unconditionally.
- PREADY=1 only in ACK, giving exactly one wait state.
REQ-014 A write SHALL commit on the IDLE->ACK edge; PRDATA SHALL be loaded on the same edge and held until the next access.
REQ-015 Prescaler counter pcnt SHALL count 0..PSC while EN=1; tick is asserted in the cycle pcnt==PSC, then pcnt wraps to 0.
REQ-016 On tick with CNT!=ARR, CNT SHALL increment by 1 (32-bit).
REQ-017 On tick with CNT==ARR, the timer SHALL:
- set MATCH and clear CNT to 0;
- additionally clear EN if AUTORELOAD=0 (one-shot).
REQ-018 With EN=0, pcnt and CNT SHALL hold.
REQ-019 A write to CNT or PSC SHALL reset pcnt to 0; a CNT write overrides a same-cycle increment.
REQ-020 A same-cycle MATCH set and STAT W1C SHALL leave MATCH=1 (set wins).
REQ-021 A same-cycle CTRL write and one-shot EN clear SHALL leave EN at the written value.
REQ-022 irq SHALL equal MATCH & IRQEN, registered-free from flops, with no extra latency.
REQ-023 PSC=0 SHALL tick every enabled cycle; PSC=0 with ARR=0 SHALL set MATCH every enabled cycle.
REQ-024 A read of CNT SHALL return the pre-update value of the capturing edge.

Reset
REQ-025 On PRESET=0, regardless of PCLK, the block SHALL clear state to:
- FSM=IDLE, PREADY=0, PRDATA=0;
- CTRL=0, PSC=0, ARR=0xFFFF_FFFF, CNT=0, pcnt=0, MATCH=0, irq=0.
REQ-026 Reset mid-transfer SHALL abort it with no register write; after release the next PSEL&PENABLE completes normally.

Structure
REQ-027 Package timer_pkg SHALL hold:
- the address offsets (0x00..0x10);
- the CTRL bit indices;
- the bus FSM state enum {IDLE, ACK}.
REQ-028 Prescaler SHALL be sub-module timer_prescaler (PCLK, PRESET, en, psc, clr -> tick); the rest stays in timer_periph.

Verification
REQ-029 Reset, then read all five offsets -> CTRL 0, PSC 0, ARR 0xFFFFFFFF, CNT 0, STAT 0; each read sees PREADY=1 exactly one cycle after PENABLE.
REQ-030 PSC=3, ARR=4, CTRL=0x7 -> CNT increments every 4 cycles; MATCH and irq rise 20 cycles after enable; CNT wraps to 0 and EN stays 1.
REQ-031 PSC=0, ARR=2, CTRL=0x1 (one-shot) -> MATCH after 3 ticks; EN reads 0; CNT holds 0; irq stays 0 since IRQEN=0.
REQ-032 STAT write 0x1 in the same cycle as a match (PSC=0, ARR=0) -> MATCH reads 1; W1C with the timer disabled -> MATCH 0, irq falls next cycle.
REQ-033 Write CNT=0x10 while running with PSC=7 -> CNT reads 0x10, next increment 8 cycles later; write to offset 0x18 -> all registers unchanged.
REQ-034 Assert PRESET during the ACK cycle of a write CTRL=0x7 -> CTRL reads 0 after release; a following read completes with one wait state.
